// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo. The FIFO takes the slave modport, and the
// producer/consumer side takes the master modport.
interface param_sync_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic             wen;
    logic             ren;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, data_in, wen, ren,
        input  data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  flush, data_in, wen, ren,
        output data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy level, almost-full/empty thresholds, optional
// first-word-fall-through read port, sticky overflow/underflow flags and a synchronous flush.
module param_sync_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : gen_bad_thresh
        $error("param_sync_fifo: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic full, empty;
    logic wr_acc, rd_acc;

    // Status is decoded purely from the registered level.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // At full a concurrent read frees the slot the write lands in.
    assign wr_acc = bus.wen && (!full || bus.ren);
    assign rd_acc = bus.ren && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + AW'(1);
            if (rd_acc) rptr_d = rptr_q + AW'(1);
            if (bus.wen && !wr_acc) ovf_d = 1'b1;
            if (bus.ren && !rd_acc) udf_d = 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!bus.flush && wr_acc) mem[wptr_q] <= bus.data_in;
    end

    if (FWFT == 1'b0) begin : gen_reg_rd
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (bus.flush) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rptr_q];
            end
        end
        assign bus.data_out = dout_q;
    end else begin : gen_fwft
        assign bus.data_out = empty ? '0 : mem[rptr_q];
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= LW'(AF_THRESH));
    assign bus.almost_empty = (level_q <= LW'(AE_THRESH));
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a registered-read instance and a FWFT instance, both
// DEPTH=16, WIDTH=8, sharing clock and reset.
module tb_param_sync_fifo;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    param_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_a ();
    param_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_b ();

    param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus_a.flush = 1'b0; bus_a.wen = 1'b0; bus_a.ren = 1'b0; bus_a.data_in = '0;
        bus_b.flush = 1'b0; bus_b.wen = 1'b0; bus_b.ren = 1'b0; bus_b.data_in = '0;
        repeat (2) tick();

        check("rst_level", 32'(bus_a.level), 0);
        check("rst_empty", 32'(bus_a.empty), 1);
        check("rst_full", 32'(bus_a.full), 0);
        check("rst_ae", 32'(bus_a.almost_empty), 1);
        check("rst_dout", 32'(bus_a.data_out), 0);
        check("rst_ovf", 32'(bus_a.overflow), 0);
        check("rst_udf", 32'(bus_a.underflow), 0);
        check("rst_b_dout", 32'(bus_b.data_out), 0);
        rst = 1'b1;
        tick();

        // 1: fill to full
        for (int i = 0; i < 16; i++) begin
            bus_a.wen = 1'b1;
            bus_a.data_in = 8'(i + 1);
            tick();
            check("fill_level", 32'(bus_a.level), 32'(i + 1));
            check("fill_af", 32'(bus_a.almost_full), (i + 1 >= 14) ? 1 : 0);
            check("fill_full", 32'(bus_a.full), (i + 1 == 16) ? 1 : 0);
        end

        // 2: overflow, then drain in order
        bus_a.data_in = 8'hFF;
        tick();
        bus_a.wen = 1'b0;
        check("ovf_flag", 32'(bus_a.overflow), 1);
        check("ovf_level", 32'(bus_a.level), 16);
        bus_a.ren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_data", 32'(bus_a.data_out), 32'(i + 1));
            check("drain_level", 32'(bus_a.level), 32'(15 - i));
            check("drain_ae", 32'(bus_a.almost_empty), (15 - i <= 2) ? 1 : 0);
        end
        check("drain_empty", 32'(bus_a.empty), 1);

        // 3: underflow, then flush clears both sticky flags
        tick();
        bus_a.ren = 1'b0;
        check("udf_flag", 32'(bus_a.underflow), 1);
        check("udf_level", 32'(bus_a.level), 0);
        check("udf_dout_held", 32'(bus_a.data_out), 32'h10);
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        check("flush_udf", 32'(bus_a.underflow), 0);
        check("flush_ovf", 32'(bus_a.overflow), 0);
        check("flush_dout", 32'(bus_a.data_out), 0);

        // 4: ordering across pointer wrap
        bus_a.wen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_a.data_in = 8'(8'h40 + i);
            tick();
        end
        bus_a.wen = 1'b0;
        bus_a.ren = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pre_wrap_data", 32'(bus_a.data_out), 32'(8'h40 + i));
        end
        bus_a.ren = 1'b0;
        bus_a.wen = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus_a.data_in = 8'(8'h20 + i);
            tick();
        end
        bus_a.wen = 1'b0;
        check("wrap_level", 32'(bus_a.level), 12);
        bus_a.ren = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("wrap_data", 32'(bus_a.data_out), 32'(8'h20 + i));
        end
        bus_a.ren = 1'b0;
        check("wrap_level0", 32'(bus_a.level), 0);

        // 5: simultaneous read/write at full
        bus_a.wen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_a.data_in = 8'(8'h30 + i);
            tick();
        end
        check("full5", 32'(bus_a.full), 1);
        bus_a.ren = 1'b1;
        bus_a.data_in = 8'hAA;
        tick();
        bus_a.wen = 1'b0;
        check("rw_full_dout", 32'(bus_a.data_out), 32'h30);
        check("rw_full_level", 32'(bus_a.level), 16);
        check("rw_full_ovf", 32'(bus_a.overflow), 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("rw_full_drain", 32'(bus_a.data_out), (i < 15) ? 32'(8'h31 + i) : 32'hAA);
        end

        // Simultaneous read/write at empty: write only, read rejected
        bus_a.wen = 1'b1;
        bus_a.data_in = 8'h77;
        tick();
        bus_a.wen = 1'b0;
        bus_a.ren = 1'b0;
        check("rw_empty_level", 32'(bus_a.level), 1);
        check("rw_empty_udf", 32'(bus_a.underflow), 1);
        check("rw_empty_dout", 32'(bus_a.data_out), 32'hAA);

        // Flush wins over a concurrent write
        bus_a.flush = 1'b1;
        bus_a.wen = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        bus_a.wen = 1'b0;
        check("flush_wen_level", 32'(bus_a.level), 0);
        check("flush_wen_empty", 32'(bus_a.empty), 1);

        // 6: FWFT instance
        check("fwft_idle_dout", 32'(bus_b.data_out), 0);
        bus_b.wen = 1'b1;
        bus_b.data_in = 8'h5A;
        tick();
        bus_b.wen = 1'b0;
        check("fwft_empty", 32'(bus_b.empty), 0);
        check("fwft_dout", 32'(bus_b.data_out), 32'h5A);
        bus_b.wen = 1'b1;
        bus_b.data_in = 8'h5B;
        tick();
        bus_b.data_in = 8'h5C;
        tick();
        bus_b.wen = 1'b0;
        check("fwft_head_held", 32'(bus_b.data_out), 32'h5A);
        bus_b.ren = 1'b1;
        tick();
        bus_b.ren = 1'b0;
        check("fwft_pop_dout", 32'(bus_b.data_out), 32'h5B);
        check("fwft_pop_level", 32'(bus_b.level), 2);

        // Asynchronous reset in the middle of a write burst
        bus_b.wen = 1'b1;
        bus_b.data_in = 8'h60;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_level", 32'(bus_b.level), 0);
        check("arst_empty", 32'(bus_b.empty), 1);
        check("arst_full", 32'(bus_b.full), 0);
        check("arst_ae", 32'(bus_b.almost_empty), 1);
        check("arst_dout", 32'(bus_b.data_out), 0);
        check("arst_ovf", 32'(bus_b.overflow), 0);
        check("arst_a_dout", 32'(bus_a.data_out), 0);
        check("arst_a_udf", 32'(bus_a.underflow), 0);
        bus_b.wen = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("arst_hold_level", 32'(bus_b.level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
